// File: rtl/axi_read_arbiter_2to1.sv
// axi_read_arbiter_2to1: two-master AXI4 read-channel arbiter sharing one
// downstream read port. One transaction in flight, grant held from AR accept
// to the RLAST beat, round-robin between masters. No ID remapping.
// Optional feature macro: AXI_ARB_QOS_EN (higher ARQOS wins a tie in IDLE).
module axi_read_arbiter_2to1 #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // master 0
    input  logic                  s0_ARVALID,
    output logic                  s0_ARREADY,
    input  logic [ID_WIDTH-1:0]   s0_ARID,
    input  logic [ADDR_WIDTH-1:0] s0_ARADDR,
    input  logic [7:0]            s0_ARLEN,
    input  logic [2:0]            s0_ARSIZE,
    input  logic [1:0]            s0_ARBURST,
    input  logic                  s0_ARLOCK,
    input  logic [3:0]            s0_ARCACHE,
    input  logic [2:0]            s0_ARPROT,
    input  logic [3:0]            s0_ARQOS,
    input  logic [3:0]            s0_ARREGION,
    input  logic [USER_WIDTH-1:0] s0_ARUSER,
    output logic [ID_WIDTH-1:0]   s0_RID,
    output logic [DATA_WIDTH-1:0] s0_RDATA,
    output logic [1:0]            s0_RRESP,
    output logic                  s0_RLAST,
    output logic [USER_WIDTH-1:0] s0_RUSER,
    output logic                  s0_RVALID,
    input  logic                  s0_RREADY,
    // master 1
    input  logic                  s1_ARVALID,
    output logic                  s1_ARREADY,
    input  logic [ID_WIDTH-1:0]   s1_ARID,
    input  logic [ADDR_WIDTH-1:0] s1_ARADDR,
    input  logic [7:0]            s1_ARLEN,
    input  logic [2:0]            s1_ARSIZE,
    input  logic [1:0]            s1_ARBURST,
    input  logic                  s1_ARLOCK,
    input  logic [3:0]            s1_ARCACHE,
    input  logic [2:0]            s1_ARPROT,
    input  logic [3:0]            s1_ARQOS,
    input  logic [3:0]            s1_ARREGION,
    input  logic [USER_WIDTH-1:0] s1_ARUSER,
    output logic [ID_WIDTH-1:0]   s1_RID,
    output logic [DATA_WIDTH-1:0] s1_RDATA,
    output logic [1:0]            s1_RRESP,
    output logic                  s1_RLAST,
    output logic [USER_WIDTH-1:0] s1_RUSER,
    output logic                  s1_RVALID,
    input  logic                  s1_RREADY,
    // downstream port
    output logic                  m_ARVALID,
    input  logic                  m_ARREADY,
    output logic [ID_WIDTH-1:0]   m_ARID,
    output logic [ADDR_WIDTH-1:0] m_ARADDR,
    output logic [7:0]            m_ARLEN,
    output logic [2:0]            m_ARSIZE,
    output logic [1:0]            m_ARBURST,
    output logic                  m_ARLOCK,
    output logic [3:0]            m_ARCACHE,
    output logic [2:0]            m_ARPROT,
    output logic [3:0]            m_ARQOS,
    output logic [3:0]            m_ARREGION,
    output logic [USER_WIDTH-1:0] m_ARUSER,
    input  logic [ID_WIDTH-1:0]   m_RID,
    input  logic [DATA_WIDTH-1:0] m_RDATA,
    input  logic [1:0]            m_RRESP,
    input  logic                  m_RLAST,
    input  logic [USER_WIDTH-1:0] m_RUSER,
    input  logic                  m_RVALID,
    output logic                  m_RREADY,
    // status
    output logic                  arb_busy,
    output logic                  arb_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   winner_s;

    // AR fields always show the granted master, even outside ADDR
    assign m_ARID     = grant_q ? s1_ARID     : s0_ARID;
    assign m_ARADDR   = grant_q ? s1_ARADDR   : s0_ARADDR;
    assign m_ARLEN    = grant_q ? s1_ARLEN    : s0_ARLEN;
    assign m_ARSIZE   = grant_q ? s1_ARSIZE   : s0_ARSIZE;
    assign m_ARBURST  = grant_q ? s1_ARBURST  : s0_ARBURST;
    assign m_ARLOCK   = grant_q ? s1_ARLOCK   : s0_ARLOCK;
    assign m_ARCACHE  = grant_q ? s1_ARCACHE  : s0_ARCACHE;
    assign m_ARPROT   = grant_q ? s1_ARPROT   : s0_ARPROT;
    assign m_ARQOS    = grant_q ? s1_ARQOS    : s0_ARQOS;
    assign m_ARREGION = grant_q ? s1_ARREGION : s0_ARREGION;
    assign m_ARUSER   = grant_q ? s1_ARUSER   : s0_ARUSER;

    // R payload goes to both masters; only RVALID is steered
    assign s0_RID   = m_RID;
    assign s0_RDATA = m_RDATA;
    assign s0_RRESP = m_RRESP;
    assign s0_RLAST = m_RLAST;
    assign s0_RUSER = m_RUSER;
    assign s1_RID   = m_RID;
    assign s1_RDATA = m_RDATA;
    assign s1_RRESP = m_RRESP;
    assign s1_RLAST = m_RLAST;
    assign s1_RUSER = m_RUSER;

    assign arb_busy  = (state_q != ST_IDLE);
    assign arb_grant = grant_q;

    // Arbitration winner: single requester wins, a tie goes away from last_grant
    always_comb begin
        winner_s = 1'b0;
        if (s0_ARVALID && s1_ARVALID) begin
`ifdef AXI_ARB_QOS_EN
            if (s0_ARQOS > s1_ARQOS) begin
                winner_s = 1'b0;
            end else if (s1_ARQOS > s0_ARQOS) begin
                winner_s = 1'b1;
            end else begin
                winner_s = ~last_grant_q;
            end
`else
            winner_s = ~last_grant_q;
`endif
        end else if (s1_ARVALID) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state and handshake steering for the IDLE/ADDR/DATA sequence
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_ARVALID    = 1'b0;
        m_RREADY     = 1'b0;
        s0_ARREADY   = 1'b0;
        s1_ARREADY   = 1'b0;
        s0_RVALID    = 1'b0;
        s1_RVALID    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s0_ARVALID || s1_ARVALID) begin
                    grant_d = winner_s;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // a granted master dropping ARVALID keeps the grant
                m_ARVALID  = grant_q ? s1_ARVALID : s0_ARVALID;
                s0_ARREADY = ~grant_q & m_ARREADY;
                s1_ARREADY = grant_q & m_ARREADY;
                if (m_ARVALID && m_ARREADY) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                s0_RVALID = ~grant_q & m_RVALID;
                s1_RVALID = grant_q & m_RVALID;
                m_RREADY  = grant_q ? s1_RREADY : s0_RREADY;
                // RLAST is the only burst terminator; beats are not counted
                if (m_RVALID && m_RREADY && m_RLAST) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin history registers with synchronous reset
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter_2to1.sv
// Directed self-checking bench for axi_read_arbiter_2to1.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_axi_read_arbiter_2to1;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          s0_ARVALID, s0_ARREADY, s0_ARLOCK, s0_RLAST, s0_RVALID, s0_RREADY;
    logic [7:0]    s0_ARID, s0_ARLEN, s0_ARUSER, s0_RID, s0_RUSER;
    logic [63:0]   s0_ARADDR;
    logic [2:0]    s0_ARSIZE, s0_ARPROT;
    logic [1:0]    s0_ARBURST, s0_RRESP;
    logic [3:0]    s0_ARCACHE, s0_ARQOS, s0_ARREGION;
    logic [1023:0] s0_RDATA;
    logic          s1_ARVALID, s1_ARREADY, s1_ARLOCK, s1_RLAST, s1_RVALID, s1_RREADY;
    logic [7:0]    s1_ARID, s1_ARLEN, s1_ARUSER, s1_RID, s1_RUSER;
    logic [63:0]   s1_ARADDR;
    logic [2:0]    s1_ARSIZE, s1_ARPROT;
    logic [1:0]    s1_ARBURST, s1_RRESP;
    logic [3:0]    s1_ARCACHE, s1_ARQOS, s1_ARREGION;
    logic [1023:0] s1_RDATA;
    logic          m_ARVALID, m_ARREADY, m_ARLOCK, m_RLAST, m_RVALID, m_RREADY;
    logic [7:0]    m_ARID, m_ARLEN, m_ARUSER, m_RID, m_RUSER;
    logic [63:0]   m_ARADDR;
    logic [2:0]    m_ARSIZE, m_ARPROT;
    logic [1:0]    m_ARBURST, m_RRESP;
    logic [3:0]    m_ARCACHE, m_ARQOS, m_ARREGION;
    logic [1023:0] m_RDATA;
    logic          arb_busy, arb_grant;

    int total = 0;
    int bad   = 0;
    logic exp_first;

    always #5 ACLK = ~ACLK;

    axi_read_arbiter_2to1 dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s0_ARVALID(s0_ARVALID), .s0_ARREADY(s0_ARREADY), .s0_ARID(s0_ARID), .s0_ARADDR(s0_ARADDR),
        .s0_ARLEN(s0_ARLEN), .s0_ARSIZE(s0_ARSIZE), .s0_ARBURST(s0_ARBURST), .s0_ARLOCK(s0_ARLOCK),
        .s0_ARCACHE(s0_ARCACHE), .s0_ARPROT(s0_ARPROT), .s0_ARQOS(s0_ARQOS), .s0_ARREGION(s0_ARREGION),
        .s0_ARUSER(s0_ARUSER), .s0_RID(s0_RID), .s0_RDATA(s0_RDATA), .s0_RRESP(s0_RRESP),
        .s0_RLAST(s0_RLAST), .s0_RUSER(s0_RUSER), .s0_RVALID(s0_RVALID), .s0_RREADY(s0_RREADY),
        .s1_ARVALID(s1_ARVALID), .s1_ARREADY(s1_ARREADY), .s1_ARID(s1_ARID), .s1_ARADDR(s1_ARADDR),
        .s1_ARLEN(s1_ARLEN), .s1_ARSIZE(s1_ARSIZE), .s1_ARBURST(s1_ARBURST), .s1_ARLOCK(s1_ARLOCK),
        .s1_ARCACHE(s1_ARCACHE), .s1_ARPROT(s1_ARPROT), .s1_ARQOS(s1_ARQOS), .s1_ARREGION(s1_ARREGION),
        .s1_ARUSER(s1_ARUSER), .s1_RID(s1_RID), .s1_RDATA(s1_RDATA), .s1_RRESP(s1_RRESP),
        .s1_RLAST(s1_RLAST), .s1_RUSER(s1_RUSER), .s1_RVALID(s1_RVALID), .s1_RREADY(s1_RREADY),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARID(m_ARID), .m_ARADDR(m_ARADDR),
        .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST), .m_ARLOCK(m_ARLOCK),
        .m_ARCACHE(m_ARCACHE), .m_ARPROT(m_ARPROT), .m_ARQOS(m_ARQOS), .m_ARREGION(m_ARREGION),
        .m_ARUSER(m_ARUSER), .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP),
        .m_RLAST(m_RLAST), .m_RUSER(m_RUSER), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
        .arb_busy(arb_busy), .arb_grant(arb_grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expects ADDR with grant g; accepts the AR, then streams len+1 beats.
    task automatic serve(input logic g, input logic [63:0] addr, input int len, input bit toggle);
        int b;
        int rcv;
        int cyc;
        logic rr;
        logic [63:0] pat;
        chk("addr_busy", {63'd0, arb_busy}, 64'd1);
        chk("addr_grant", {63'd0, arb_grant}, {63'd0, g});
        chk("addr_m_arvalid", {63'd0, m_ARVALID}, 64'd1);
        chk("addr_m_araddr", m_ARADDR, addr);
        chk("addr_m_arlen", {56'd0, m_ARLEN}, 64'(len));
        m_ARREADY = 1'b1;
        #1;
        chk("arready_granted", {63'd0, (g ? s1_ARREADY : s0_ARREADY)}, 64'd1);
        chk("arready_other", {63'd0, (g ? s0_ARREADY : s1_ARREADY)}, 64'd0);
        @(negedge ACLK);
        m_ARREADY = 1'b0;
        if (g) s1_ARVALID = 1'b0; else s0_ARVALID = 1'b0;
        #1;
        chk("data_m_arvalid", {63'd0, m_ARVALID}, 64'd0);
        b = 0;
        rcv = 0;
        for (cyc = 0; cyc < 4 * len + 8 && b <= len; cyc++) begin
            rr = toggle ? ~cyc[0] : 1'b1;
            pat = 64'hDA7A_0000_0000_0000 | 64'(g) << 16 | 64'(b);
            m_RVALID = 1'b1;
            m_RLAST  = (b == len);
            m_RDATA  = {16{pat}};
            if (g) begin s1_RREADY = rr; s0_RREADY = 1'b1; end
            else   begin s0_RREADY = rr; s1_RREADY = 1'b1; end
            #1;
            chk("rvalid_granted", {63'd0, (g ? s1_RVALID : s0_RVALID)}, 64'd1);
            chk("rvalid_other", {63'd0, (g ? s0_RVALID : s1_RVALID)}, 64'd0);
            chk("m_rready_mirror", {63'd0, m_RREADY}, {63'd0, rr});
            chk("rdata_fwd", (g ? s1_RDATA[63:0] : s0_RDATA[63:0]), pat);
            if ((g ? s1_RVALID : s0_RVALID) && rr) rcv++;
            if (rr) b++;
            @(negedge ACLK);
        end
        m_RVALID = 1'b0;
        m_RLAST  = 1'b0;
        #1;
        chk("beat_count", 64'(rcv), 64'(len + 1));
        chk("idle_after_rlast", {63'd0, arb_busy}, 64'd0);
        chk("grant_after_rlast", {63'd0, arb_grant}, {63'd0, g});
    endtask

    initial begin
        ARESETn = 1'b0;
        {s0_ARVALID, s0_ARLOCK, s0_RREADY, s1_ARVALID, s1_ARLOCK, s1_RREADY} = 6'd0;
        {s0_ARID, s0_ARLEN, s0_ARUSER, s1_ARID, s1_ARLEN, s1_ARUSER} = 48'd0;
        s0_ARADDR = 64'd0; s1_ARADDR = 64'd0;
        {s0_ARSIZE, s0_ARPROT, s1_ARSIZE, s1_ARPROT} = 12'd0;
        {s0_ARBURST, s1_ARBURST} = 4'd0;
        {s0_ARCACHE, s0_ARQOS, s0_ARREGION, s1_ARCACHE, s1_ARQOS, s1_ARREGION} = 24'd0;
        {m_ARREADY, m_RLAST, m_RVALID} = 3'd0;
        {m_RID, m_RUSER} = 16'd0;
        m_RRESP = 2'd0;
        m_RDATA = 1024'd0;

        // 1: reset held 3 cycles with a pending s0 request and stray R valid
        s0_ARVALID = 1'b1;
        m_RVALID   = 1'b1;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_m_arvalid", {63'd0, m_ARVALID}, 64'd0);
        chk("rst_m_rready", {63'd0, m_RREADY}, 64'd0);
        chk("rst_s0_arready", {63'd0, s0_ARREADY}, 64'd0);
        chk("rst_s1_arready", {63'd0, s1_ARREADY}, 64'd0);
        chk("rst_s0_rvalid", {63'd0, s0_RVALID}, 64'd0);
        chk("rst_s1_rvalid", {63'd0, s1_RVALID}, 64'd0);
        chk("rst_busy", {63'd0, arb_busy}, 64'd0);
        chk("rst_grant", {63'd0, arb_grant}, 64'd0);
        s0_ARVALID = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        #1;
        chk("idle_ignores_rvalid", {63'd0, m_RREADY}, 64'd0);
        m_RVALID = 1'b0;

        // 2: single s0 read, LEN=3
        @(negedge ACLK);
        s0_ARVALID = 1'b1; s0_ARADDR = 64'h1000; s0_ARLEN = 8'd3;
        #1;
        chk("req_cycle_m_arvalid", {63'd0, m_ARVALID}, 64'd0);
        @(negedge ACLK);
        serve(1'b0, 64'h1000, 3, 1'b0);

        // 4: s1 alone, LEN=7, RREADY toggling 1010
        @(negedge ACLK);
        s1_ARVALID = 1'b1; s1_ARADDR = 64'h2000; s1_ARLEN = 8'd7;
        @(negedge ACLK);
        serve(1'b1, 64'h2000, 7, 1'b1);

        // 3: contention twice, LEN=0, expect s0 then s1 each round
        for (int r = 0; r < 2; r++) begin
            @(negedge ACLK);
            s0_ARVALID = 1'b1; s0_ARADDR = 64'h5000; s0_ARLEN = 8'd0;
            s1_ARVALID = 1'b1; s1_ARADDR = 64'h6000; s1_ARLEN = 8'd0;
            @(negedge ACLK);
            serve(1'b0, 64'h5000, 0, 1'b0);
            @(negedge ACLK);
            serve(1'b1, 64'h6000, 0, 1'b0);
        end

        // 5: reset at beat 2 of an s0 LEN=7 burst
        @(negedge ACLK);
        s0_ARVALID = 1'b1; s0_ARADDR = 64'h3000; s0_ARLEN = 8'd7;
        @(negedge ACLK);
        chk("mid_grant", {63'd0, arb_grant}, 64'd0);
        m_ARREADY = 1'b1;
        @(negedge ACLK);
        m_ARREADY = 1'b0; s0_ARVALID = 1'b0; s0_RREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_RVALID = 1'b1; m_RLAST = 1'b0; m_RDATA = 1024'(i);
            @(negedge ACLK);
        end
        ARESETn = 1'b0;
        #1;
        chk("mid_busy_before", {63'd0, arb_busy}, 64'd1);
        @(negedge ACLK);
        #1;
        chk("mid_rst_busy", {63'd0, arb_busy}, 64'd0);
        chk("mid_rst_m_rready", {63'd0, m_RREADY}, 64'd0);
        chk("mid_rst_s0_rvalid", {63'd0, s0_RVALID}, 64'd0);
        ARESETn = 1'b1; m_RVALID = 1'b0;
        @(negedge ACLK);
        s1_ARVALID = 1'b1; s1_ARADDR = 64'h4000; s1_ARLEN = 8'd1;
        @(negedge ACLK);
        serve(1'b1, 64'h4000, 1, 1'b0);

        // 6: simultaneous requests, s0 QOS=2, s1 QOS=9, last_grant=1
`ifdef AXI_ARB_QOS_EN
        exp_first = 1'b1;
`else
        exp_first = 1'b0;
`endif
        @(negedge ACLK);
        s0_ARVALID = 1'b1; s0_ARADDR = 64'h7000; s0_ARLEN = 8'd0; s0_ARQOS = 4'd2;
        s1_ARVALID = 1'b1; s1_ARADDR = 64'h8000; s1_ARLEN = 8'd0; s1_ARQOS = 4'd9;
        @(negedge ACLK);
        chk("qos_m_arqos", {60'd0, m_ARQOS}, (exp_first ? 64'd9 : 64'd2));
        serve(exp_first, (exp_first ? 64'h8000 : 64'h7000), 0, 1'b0);
        @(negedge ACLK);
        serve(~exp_first, (exp_first ? 64'h7000 : 64'h8000), 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
